// File: rtl/tpu_pkg.sv
// Shared constants for the TPU output path: lane geometry, Q5.3 fixed-point
// layout and activation-type encodings.
package tpu_pkg;

    localparam int DWIDTH      = 8;
    localparam int DESIGN_SIZE = 16;
    localparam int MASK_WIDTH  = 16;
    localparam int ROW_CNT_W   = 8;
    localparam int ROW_W       = DESIGN_SIZE * DWIDTH;

    // Q5.3: three fractional bits, so 1.0 == 8 and 0.5 == 4.
    localparam int FRAC_BITS   = 3;

    localparam logic ACT_RELU  = 1'b0;
    localparam logic ACT_HSIG  = 1'b1;

    // Hard-sigmoid is clamp(x/4 + 0.5, 0, 1.0).
    localparam int HSIG_SHIFT  = 2;
    localparam int HSIG_OFFSET = 1 << (FRAC_BITS - 1);
    localparam int HSIG_CEIL   = 1 << FRAC_BITS;

endpackage

// File: rtl/act_lane.sv
// One activation lane: bypass / ReLU / hard-sigmoid on a Q5.3 value, then
// forced to zero when the lane is marked invalid. Purely combinational.
module act_lane
    import tpu_pkg::*;
(
    input  logic [DWIDTH-1:0] x,
    input  logic              en,
    input  logic              act_type,
    input  logic              valid,
    output logic [DWIDTH-1:0] y
);

    // One extra bit so x/4 + 0.5 never overflows for any 8-bit input.
    localparam int SW = DWIDTH + 1;
    localparam logic signed [SW-1:0] OFFSET  = SW'(HSIG_OFFSET);
    localparam logic signed [SW-1:0] CEIL    = SW'(HSIG_CEIL);
    localparam logic [DWIDTH-1:0]    CEIL_Y  = DWIDTH'(HSIG_CEIL);

    logic signed [SW-1:0] xs;
    logic signed [SW-1:0] hs;
    logic [DWIDTH-1:0]    hsig_y;
    logic [DWIDTH-1:0]    relu_y;
    logic [DWIDTH-1:0]    func_y;

    // Per-lane activation followed by the validity mask.
    always_comb begin
        xs     = {x[DWIDTH-1], x};
        hs     = (xs >>> HSIG_SHIFT) + OFFSET;
        hsig_y = '0;
        if (hs[SW-1]) begin
            hsig_y = '0;
        end else if (hs > CEIL) begin
            hsig_y = CEIL_Y;
        end else begin
            hsig_y = hs[DWIDTH-1:0];
        end

        relu_y = x[DWIDTH-1] ? '0 : x;

        func_y = x;
        if (en) begin
            func_y = (act_type == ACT_HSIG) ? hsig_y : relu_y;
        end

        y = valid ? func_y : '0;
    end

endmodule

// File: rtl/act_stage.sv
// Activation stage after pooling: two-register pipeline (input capture, then
// activated/masked output), a saturating row counter and a sticky done flag.
module act_stage
    import tpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_activation,
    input  logic                 activation_type,
    input  logic [ROW_CNT_W-1:0] num_rows,
    input  logic                 in_data_available,
    input  logic [ROW_W-1:0]     inp_data,
    input  logic [MASK_WIDTH-1:0] validity_mask,
    output logic [ROW_W-1:0]     out_data,
    output logic                 out_data_available,
    output logic                 done_activation
);

    localparam logic [ROW_CNT_W-1:0] CNT_ONE = {{(ROW_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ROW_CNT_W-1:0] CNT_MAX = '1;

    // First stage: the beat plus the config it arrived with.
    logic                  s1_valid;
    logic [ROW_W-1:0]      s1_data;
    logic [MASK_WIDTH-1:0] s1_mask;
    logic                  s1_en;
    logic                  s1_type;
    logic                  s1_last;

    logic [ROW_CNT_W-1:0]  row_cnt;
    logic [ROW_CNT_W-1:0]  row_cnt_inc;
    logic                  beat_is_last;
    logic [ROW_W-1:0]      lane_y;

    // A beat is the final row of the pass only if it actually moves the
    // counter onto num_rows; once saturated, later beats never re-qualify,
    // and num_rows == 0 is unreachable from a nonzero increment.
    always_comb begin
        row_cnt_inc  = row_cnt + CNT_ONE;
        beat_is_last = (row_cnt != CNT_MAX) && (row_cnt_inc == num_rows);
    end

    // Input capture and row counting; reset wins over an arriving beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mask  <= '0;
            s1_en    <= 1'b0;
            s1_type  <= ACT_RELU;
            s1_last  <= 1'b0;
            row_cnt  <= '0;
        end else begin
            s1_valid <= in_data_available;
            if (in_data_available) begin
                s1_data <= inp_data;
                s1_mask <= validity_mask;
                s1_en   <= enable_activation;
                s1_type <= activation_type;
                s1_last <= beat_is_last;
                if (row_cnt != CNT_MAX) begin
                    row_cnt <= row_cnt_inc;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DESIGN_SIZE; gi++) begin : g_lane
            act_lane u_lane (
                .x        (s1_data[gi*DWIDTH +: DWIDTH]),
                .en       (s1_en),
                .act_type (s1_type),
                .valid    (s1_mask[gi]),
                .y        (lane_y[gi*DWIDTH +: DWIDTH])
            );
        end
    endgenerate

    // Output register; data holds across gaps, done latches with the last row.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data           <= '0;
            out_data_available <= 1'b0;
            done_activation    <= 1'b0;
        end else begin
            out_data_available <= s1_valid;
            if (s1_valid) begin
                out_data <= lane_y;
                if (s1_last) begin
                    done_activation <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_act_stage.sv
module tb_act_stage;

    logic         clk;
    logic         reset;
    logic         enable_activation;
    logic         activation_type;
    logic [7:0]   num_rows;
    logic         in_data_available;
    logic [127:0] inp_data;
    logic [15:0]  validity_mask;
    logic [127:0] out_data;
    logic         out_data_available;
    logic         done_activation;

    int checks;
    int failures;

    act_stage dut (
        .clk                (clk),
        .reset              (reset),
        .enable_activation  (enable_activation),
        .activation_type    (activation_type),
        .num_rows           (num_rows),
        .in_data_available  (in_data_available),
        .inp_data           (inp_data),
        .validity_mask      (validity_mask),
        .out_data           (out_data),
        .out_data_available (out_data_available),
        .done_activation    (done_activation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] splat(input logic [7:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    task automatic idle_inputs();
        in_data_available = 1'b0;
        inp_data          = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable_activation = 1'b1;
        activation_type = 1'b0;
        num_rows = 8'd0;
        validity_mask = 16'hFFFF;
        idle_inputs();
        step(); step();
        checks++;
        if (out_data !== 128'd0) begin
            failures++; $display("FAIL reset_out_data got=%h exp=0", out_data);
        end
        checks++;
        if (out_data_available !== 1'b0) begin
            failures++; $display("FAIL reset_avail got=%b exp=0", out_data_available);
        end
        checks++;
        if (done_activation !== 1'b0) begin
            failures++; $display("FAIL reset_done got=%b exp=0", done_activation);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_relu();
        logic [127:0] exp_row;
        enable_activation = 1'b1;
        activation_type = 1'b0;
        validity_mask = 16'hFFFF;
        inp_data = '0;
        inp_data[0*8 +: 8] = 8'hF8;
        inp_data[1*8 +: 8] = 8'h14;
        inp_data[2*8 +: 8] = 8'h00;
        inp_data[3*8 +: 8] = 8'h7F;
        inp_data[4*8 +: 8] = 8'h80;
        exp_row = '0;
        exp_row[1*8 +: 8] = 8'h14;
        exp_row[3*8 +: 8] = 8'h7F;
        in_data_available = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (out_data_available !== 1'b0) begin
            failures++; $display("FAIL relu_avail_early got=%b exp=0", out_data_available);
        end
        step();
        checks++;
        if (out_data_available !== 1'b1) begin
            failures++; $display("FAIL relu_avail got=%b exp=1", out_data_available);
        end
        checks++;
        if (out_data !== exp_row) begin
            failures++; $display("FAIL relu_data got=%h exp=%h", out_data, exp_row);
        end
        step();
        checks++;
        if (out_data_available !== 1'b0 || out_data !== exp_row) begin
            failures++;
            $display("FAIL relu_hold got avail=%b data=%h exp avail=0 data=%h",
                     out_data_available, out_data, exp_row);
        end
    endtask

    task automatic test_hsig();
        logic [7:0] xin [7];
        logic [7:0] yexp [7];
        logic [127:0] exp_row;
        xin  = '{8'h00, 8'h08, 8'hF8, 8'h10, 8'hF0, 8'h7F, 8'h80};
        yexp = '{8'h04, 8'h06, 8'h02, 8'h08, 8'h00, 8'h08, 8'h00};
        enable_activation = 1'b1;
        activation_type = 1'b1;
        validity_mask = 16'hFFFF;
        inp_data = '0;
        exp_row = splat(8'h04);
        for (int i = 0; i < 7; i++) begin
            inp_data[i*8 +: 8] = xin[i];
            exp_row[i*8 +: 8]  = yexp[i];
        end
        in_data_available = 1'b1;
        step();
        idle_inputs();
        step();
        checks++;
        if (out_data_available !== 1'b1) begin
            failures++; $display("FAIL hsig_avail got=%b exp=1", out_data_available);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_data[i*8 +: 8] !== exp_row[i*8 +: 8]) begin
                failures++;
                $display("FAIL hsig_lane%0d got=%h exp=%h", i, out_data[i*8 +: 8], exp_row[i*8 +: 8]);
            end
        end
        step();
    endtask

    task automatic test_bypass_mask();
        logic [127:0] exp_row;
        enable_activation = 1'b0;
        activation_type = 1'b1;
        validity_mask = 16'h00FF;
        exp_row = '0;
        for (int i = 0; i < 16; i++) begin
            inp_data[i*8 +: 8] = 8'(i << 3);
            if (i < 8) exp_row[i*8 +: 8] = 8'(i << 3);
        end
        in_data_available = 1'b1;
        step();
        idle_inputs();
        step();
        checks++;
        if (out_data_available !== 1'b1 || out_data !== exp_row) begin
            failures++;
            $display("FAIL bypass_mask got avail=%b data=%h exp avail=1 data=%h",
                     out_data_available, out_data, exp_row);
        end
        step();
    endtask

    task automatic test_done_count();
        logic exp_avail;
        logic exp_done;
        logic [7:0] beat_val [16];
        reset = 1'b1;
        step();
        reset = 1'b0;
        enable_activation = 1'b1;
        activation_type = 1'b0;
        validity_mask = 16'hFFFF;
        num_rows = 8'd4;
        for (int c = 0; c < 16; c++) begin
            beat_val[c] = 8'(c + 1);
            exp_avail = (c == 2) || (c == 3) || (c == 5) || (c == 9) || (c == 13) || (c == 14);
            exp_done  = (c >= 9);
            checks++;
            if (out_data_available !== exp_avail) begin
                failures++;
                $display("FAIL done_avail_c%0d got=%b exp=%b", c, out_data_available, exp_avail);
            end
            checks++;
            if (done_activation !== exp_done) begin
                failures++;
                $display("FAIL done_flag_c%0d got=%b exp=%b", c, done_activation, exp_done);
            end
            if (exp_avail) begin
                checks++;
                if (out_data !== splat(beat_val[c-2])) begin
                    failures++;
                    $display("FAIL done_data_c%0d got=%h exp=%h", c, out_data, splat(beat_val[c-2]));
                end
            end
            in_data_available = (c == 0) || (c == 1) || (c == 3) || (c == 7) || (c == 11) || (c == 12);
            inp_data = splat(beat_val[c]);
            step();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back_toggle();
        logic [7:0] yexp [3];
        yexp = '{8'h00, 8'h02, 8'h00};
        enable_activation = 1'b1;
        validity_mask = 16'hFFFF;
        num_rows = 8'd0;
        inp_data = splat(8'hF8);
        for (int c = 0; c < 5; c++) begin
            if (c >= 2) begin
                checks++;
                if (out_data_available !== 1'b1 || out_data !== splat(yexp[c-2])) begin
                    failures++;
                    $display("FAIL toggle_c%0d got avail=%b data=%h exp avail=1 data=%h",
                             c, out_data_available, out_data, splat(yexp[c-2]));
                end
            end
            in_data_available = (c < 3);
            activation_type = (c == 1);
            step();
        end
        idle_inputs();
        activation_type = 1'b0;
    endtask

    task automatic test_reset_midstream();
        enable_activation = 1'b1;
        activation_type = 1'b0;
        validity_mask = 16'hFFFF;
        num_rows = 8'd1;
        inp_data = splat(8'h11);
        in_data_available = 1'b1;
        step();
        inp_data = splat(8'h22);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out_data_available !== 1'b0 || done_activation !== 1'b0 || out_data !== 128'd0) begin
                failures++;
                $display("FAIL rst_mid_c%0d got avail=%b done=%b data=%h exp 0/0/0",
                         c, out_data_available, done_activation, out_data);
            end
            step();
        end
        inp_data = splat(8'h33);
        in_data_available = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (out_data_available !== 1'b0 || done_activation !== 1'b0) begin
            failures++;
            $display("FAIL rst_pass_early got avail=%b done=%b exp 0/0", out_data_available, done_activation);
        end
        step();
        checks++;
        if (out_data_available !== 1'b1 || done_activation !== 1'b1 || out_data !== splat(8'h33)) begin
            failures++;
            $display("FAIL rst_pass_done got avail=%b done=%b data=%h exp 1/1/%h",
                     out_data_available, done_activation, out_data, splat(8'h33));
        end
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_relu();
        test_hsig();
        test_bypass_mask();
        test_done_count();
        test_back_to_back_toggle();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
